fetch_pc_unit: RTL and testbench

- Program-counter and fetch-control stage of the single-cycle RISC-V CPU.
- Sits directly upstream of the 1K x 32 instruction ROM: drives the 10-bit ROM word address, selects the next PC (sequential, branch, jal, jalr), and implements the run/pause/halt control used by ecall services.
- Also keeps the statistics counters shown on the board display: total cycles, jumps, and taken branches.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_pc_unit_stat_counter.sv | 20 ++
 rtl/fetch_pc_unit.sv | 132 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch / program-counter stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        PAUSE,
        HALT
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JAL,
        SEL_JALR,
        SEL_HOLD
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    // Force a redirect target onto a word boundary (bits 1:0 cleared).
    function automatic logic [31:0] word_align(input logic [31:0] target);
        return target & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_stat_counter.sv
// Wrapping statistics counter with enable and asynchronous reset.
module stat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count up by one when enabled; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, next-PC selection, run/pause/halt control and
// statistics counters for the single-cycle RISC-V fetch stage.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              halt_req,
    input  logic              pause_req,
    input  logic              branch_taken,
    input  logic              jal,
    input  logic              jalr,
    input  logic [31:0]       br_target,
    input  logic [31:0]       jalr_target,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  jmp_cnt,
    output logic [CNT_W-1:0]  br_cnt
);

    fetch_state_e state;
    pc_sel_e      sel;
    logic [31:0]  next_pc;
    logic         go_q;
    logic         in_run;
    logic         ctl_taken;
    logic         jmp_en;
    logic         br_en;

    assign pc_plus4 = pc + PC_INC;
    assign rom_addr = pc[ADDR_W+1:2];

    assign in_run    = (state == RUN);
    assign ctl_taken = in_run & ~halt_req & ~pause_req;
    assign jmp_en    = ctl_taken & (jal | jalr);
    assign br_en     = ctl_taken & branch_taken & ~jal & ~jalr;

    // Next-PC source: halt > pause > jalr > jal > branch > sequential; hold outside RUN.
    always_comb begin
        sel = SEL_HOLD;
        if (in_run) begin
            if (halt_req)          sel = SEL_HOLD;
            else if (pause_req)    sel = SEL_SEQ;
            else if (jalr)         sel = SEL_JALR;
            else if (jal)          sel = SEL_JAL;
            else if (branch_taken) sel = SEL_BR;
            else                   sel = SEL_SEQ;
        end
    end

    // Next-PC value for the selected source.
    always_comb begin
        next_pc = pc;
        case (sel)
            SEL_SEQ:         next_pc = pc_plus4;
            SEL_BR, SEL_JAL: next_pc = word_align(br_target);
            SEL_JALR:        next_pc = word_align(jalr_target);
            default:         next_pc = pc;
        endcase
    end

    // Control FSM with registered status outputs, PC register and go edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            running <= 1'b1;
            halted  <= 1'b0;
            go_q    <= 1'b0;
            pc      <= RESET_PC;
        end else begin
            go_q <= go;
            pc   <= next_pc;
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state   <= HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (pause_req) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (go && !go_q) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state   <= RUN;
                    running <= 1'b1;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    stat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (in_run),
        .count (cyc_cnt)
    );

    stat_counter #(.CNT_W(CNT_W)) u_jmp_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (jmp_en),
        .count (jmp_cnt)
    );

    stat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (br_en),
        .count (br_cnt)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a behavioural reference model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        go, halt_req, pause_req, branch_taken, jal, jalr;
    logic [31:0] br_target, jalr_target;

    logic [31:0] pc, pc_plus4;
    logic [9:0]  rom_addr;
    logic        running, halted;
    logic [31:0] cyc_cnt, jmp_cnt, br_cnt;

    logic [31:0] pc4, pc_plus4_4;
    logic [9:0]  rom_addr4;
    logic        running4, halted4;
    logic [3:0]  cyc_cnt4, jmp_cnt4, br_cnt4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0), .ADDR_W(10), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .go(go), .halt_req(halt_req), .pause_req(pause_req),
        .branch_taken(branch_taken), .jal(jal), .jalr(jalr),
        .br_target(br_target), .jalr_target(jalr_target),
        .pc(pc), .pc_plus4(pc_plus4), .rom_addr(rom_addr),
        .running(running), .halted(halted),
        .cyc_cnt(cyc_cnt), .jmp_cnt(jmp_cnt), .br_cnt(br_cnt)
    );

    // Narrow-counter build to exercise counter wrap-around quickly.
    fetch_pc_unit #(.RESET_PC(32'h0), .ADDR_W(10), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .go(go), .halt_req(halt_req), .pause_req(pause_req),
        .branch_taken(branch_taken), .jal(jal), .jalr(jalr),
        .br_target(br_target), .jalr_target(jalr_target),
        .pc(pc4), .pc_plus4(pc_plus4_4), .rom_addr(rom_addr4),
        .running(running4), .halted(halted4),
        .cyc_cnt(cyc_cnt4), .jmp_cnt(jmp_cnt4), .br_cnt(br_cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = running, 1 = paused, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_cyc, m_jmp, m_br;
    bit          m_go_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pc = 32'h0; m_cyc = 0; m_jmp = 0; m_br = 0; m_go_prev = 0;
        end else begin
            if (m_mode == 0) begin
                m_cyc = m_cyc + 1;
                if (halt_req) begin
                    m_mode = 2;
                end else if (pause_req) begin
                    m_pc = m_pc + 4;
                    m_mode = 1;
                end else begin
                    if (jal || jalr) m_jmp = m_jmp + 1;
                    else if (branch_taken) m_br = m_br + 1;
                    if (jalr)                     m_pc = {jalr_target[31:2], 2'b00};
                    else if (jal || branch_taken) m_pc = {br_target[31:2], 2'b00};
                    else                          m_pc = m_pc + 4;
                end
            end else if (m_mode == 1) begin
                if (go && !m_go_prev) m_mode = 0;
            end
            m_go_prev = go;
        end
    end

    // Every-cycle comparison of both DUT builds against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("rom_addr", 32'(rom_addr), 32'(m_pc[11:2]));
            chk("running", 32'(running), 32'(m_mode == 0));
            chk("halted", 32'(halted), 32'(m_mode == 2));
            chk("cyc_cnt", cyc_cnt, m_cyc);
            chk("jmp_cnt", jmp_cnt, m_jmp);
            chk("br_cnt", br_cnt, m_br);
            chk("pc_w4", pc4, m_pc);
            chk("pc_plus4_w4", pc_plus4_4, m_pc + 32'd4);
            chk("rom_addr_w4", 32'(rom_addr4), 32'(m_pc[11:2]));
            chk("running_w4", 32'(running4), 32'(m_mode == 0));
            chk("halted_w4", 32'(halted4), 32'(m_mode == 2));
            chk("cyc_cnt_w4", 32'(cyc_cnt4), 32'(m_cyc[3:0]));
            chk("jmp_cnt_w4", 32'(jmp_cnt4), 32'(m_jmp[3:0]));
            chk("br_cnt_w4", 32'(br_cnt4), 32'(m_br[3:0]));
        end
    end

    task automatic clr();
        go = 0; halt_req = 0; pause_req = 0; branch_taken = 0; jal = 0; jalr = 0;
        br_target = 32'h0; jalr_target = 32'h0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_jal(input logic [31:0] tgt);
        jal = 1; br_target = tgt;
        @(negedge clk);
        jal = 0; br_target = 32'h0;
    endtask

    task automatic async_reset();
        #3 rst = 1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_running", 32'(running), 32'd1);
        chk("async_rst_halted", 32'(halted), 32'd0);
        chk("async_rst_cyc", cyc_cnt, 32'd0);
        chk("async_rst_jmp", jmp_cnt, 32'd0);
        @(negedge clk);
        rst = 0;
    endtask

    logic [31:0] frozen_cyc;

    initial begin
        clr();
        rst = 1;
        cycles(2);
        chk_en = 1;
        rst = 0;
        chk("lit_reset_pc", pc, 32'h0);
        chk("lit_reset_cyc", cyc_cnt, 32'd0);

        // Idle sequential fetch.
        cycles(5);
        chk("lit_idle_pc", pc, 32'h14);
        chk("lit_idle_rom", 32'(rom_addr), 32'd5);
        chk("lit_idle_cyc", cyc_cnt, 32'd5);
        chk("lit_idle_jmp", jmp_cnt, 32'd0);

        // jal then jalr with a misaligned target.
        do_jal(32'h44);
        do_jal(32'h84);
        chk("lit_jal_pc", pc, 32'h84);
        chk("lit_jal_rom", 32'(rom_addr), 32'h21);
        chk("lit_jal_jmp", jmp_cnt, 32'd2);
        jalr = 1; jalr_target = 32'h4B;
        @(negedge clk);
        jalr = 0;
        chk("lit_jalr_pc", pc, 32'h48);

        // All redirects at once: jalr wins, branch not counted.
        do_jal(32'h64);
        jal = 1; jalr = 1; branch_taken = 1; br_target = 32'h200; jalr_target = 32'h300;
        @(negedge clk);
        clr();
        chk("lit_prio_pc", pc, 32'h300);
        chk("lit_prio_jmp", jmp_cnt, 32'd5);
        chk("lit_prio_br", br_cnt, 32'd0);

        // Plain taken branch with low target bits set.
        branch_taken = 1; br_target = 32'h103;
        @(negedge clk);
        clr();
        chk("lit_br_pc", pc, 32'h100);
        chk("lit_br_cnt", br_cnt, 32'd1);

        // Pause, ignore inputs while paused, resume on go edge.
        pause_req = 1;
        @(negedge clk);
        clr();
        chk("lit_pause_pc", pc, 32'h104);
        chk("lit_pause_running", 32'(running), 32'd0);
        jal = 1; br_target = 32'h800;
        cycles(10);
        clr();
        chk("lit_paused_pc", pc, 32'h104);
        go = 1;
        @(negedge clk);
        chk("lit_resume_running", 32'(running), 32'd1);
        chk("lit_resume_pc", pc, 32'h104);
        @(negedge clk);
        chk("lit_resume_next_pc", pc, 32'h108);
        cycles(2);

        // Pause entered with go already high needs a fresh edge.
        pause_req = 1;
        @(negedge clk);
        pause_req = 0;
        cycles(3);
        chk("lit_go_held_running", 32'(running), 32'd0);
        chk("lit_go_held_pc", pc, 32'h114);
        go = 0;
        @(negedge clk);
        go = 1;
        @(negedge clk);
        go = 0;
        chk("lit_go_edge_running", 32'(running), 32'd1);

        // Halt freezes everything; go and jal ignored.
        do_jal(32'h31C);
        halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        chk("lit_halt_pc", pc, 32'h31C);
        chk("lit_halt_flag", 32'(halted), 32'd1);
        frozen_cyc = m_cyc;
        for (int i = 0; i < 20; i++) begin
            go = i[0]; jal = 1; br_target = 32'h40;
            @(negedge clk);
        end
        clr();
        chk("lit_halt_pc_frozen", pc, 32'h31C);
        chk("lit_halt_cyc_frozen", cyc_cnt, frozen_cyc);
        async_reset();

        // Reset while paused.
        cycles(2);
        pause_req = 1;
        @(negedge clk);
        pause_req = 0;
        cycles(3);
        chk("lit_midpause_running", 32'(running), 32'd0);
        async_reset();

        // Narrow counters wrap after 16 RUN cycles.
        cycles(16);
        chk("lit_wrap_cyc32", cyc_cnt, 32'd16);
        chk("lit_wrap_cyc4", 32'(cyc_cnt4), 32'd0);
        chk("lit_wrap_pc", pc, 32'h40);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
